// File: rtl/usb_fifo_pkg.sv
// usb_fifo_pkg: register map and status layout shared by the USB TX and RX FIFOs.
// Contents:
//   ADDR_*        bus register addresses (data, count MSB/LSB, force-empty, status)
//   STAT_*        bit positions inside the status register
//   statusByte()  packs the status flags into the bus read byte
package usb_fifo_pkg;

    localparam logic [2:0] ADDR_DATA        = 3'd0;
    localparam logic [2:0] ADDR_CNT_MSB     = 3'd2;
    localparam logic [2:0] ADDR_CNT_LSB     = 3'd3;
    localparam logic [2:0] ADDR_FORCE_EMPTY = 3'd4;
    localparam logic [2:0] ADDR_STATUS      = 3'd5;

    localparam int STAT_EMPTY    = 0;
    localparam int STAT_FULL     = 1;
    localparam int STAT_OVERFLOW = 2;

    function automatic logic [7:0] statusByte(input logic overflow, input logic full, input logic empty);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_OVERFLOW] = overflow;
        s[STAT_FULL]     = full;
        s[STAT_EMPTY]    = empty;
        return s;
    endfunction

endpackage

// File: rtl/usb_tx_fifo_mem.sv
// usb_tx_fifo_mem: DEPTH x 8 storage with synchronous write and a registered read port.
// Ports:
//   usbClk, rstN      clock, asynchronous active-low reset (clears only the read register)
//   wrEn/wrAddr/wrData  write one byte at the rising edge
//   rdEn/rdAddr         load rdData from rdAddr at the rising edge; rdData holds otherwise
//   rdData              registered read data
module usb_tx_fifo_mem #(
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  usbClk,
    input  logic                  rstN,
    input  logic                  wrEn,
    input  logic [ADDR_WIDTH-1:0] wrAddr,
    input  logic [7:0]            wrData,
    input  logic                  rdEn,
    input  logic [ADDR_WIDTH-1:0] rdAddr,
    output logic [7:0]            rdData
);

    logic [7:0] mem [DEPTH];

    // Storage needs no reset: contents are only visible through valid pointers.
    always_ff @(posedge usbClk) begin
        if (wrEn) mem[wrAddr] <= wrData;
    end

    always_ff @(posedge usbClk or negedge rstN) begin
        if (!rstN)     rdData <= 8'h00;
        else if (rdEn) rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/usb_tx_fifo.sv
// usb_tx_fifo: USB slave transmit FIFO with its bus register interface (single clock usbClk).
// Ports:
//   usbClk, rstN                   clock, asynchronous active-low reset
//   busAddress/busWriteEn          register select and access direction
//   busStrobe_i/busFifoSelect      access strobe and FIFO select; only the first strobed cycle acts
//   busDataIn/busDataOut           bus write data, combinational bus read data
//   fifoREn/fifoDataOut            TX engine pop request, popped byte (one cycle later)
//   fifoEmpty/fifoFull             occupancy flags
//   numElementsInFifo              occupancy, zero-extended to 16 bits
// Build option: define TX_FIFO_OVERFLOW_FLAG_EN for a sticky overflow bit in the status register.
module usb_tx_fifo
    import usb_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic        usbClk,
    input  logic        rstN,
    input  logic [2:0]  busAddress,
    input  logic        busWriteEn,
    input  logic        busStrobe_i,
    input  logic        busFifoSelect,
    input  logic [7:0]  busDataIn,
    output logic [7:0]  busDataOut,
    input  logic        fifoREn,
    output logic [7:0]  fifoDataOut,
    output logic        fifoEmpty,
    output logic        fifoFull,
    output logic [15:0] numElementsInFifo
);

    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE    = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = 1;

    logic                  accessPrev;
    logic                  accessEdge;
    logic                  wrEdge;
    logic                  push;
    logic                  pop;
    logic                  forceEmpty;
    logic                  dataWriteWhileFull;
    logic                  overflow;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH-1:0] wrPtr;
    logic [ADDR_WIDTH-1:0] rdPtr;

    // A held strobe is one access: act only on the cycle the strobe rises.
    always_comb begin
        accessEdge         = busStrobe_i & busFifoSelect & ~accessPrev;
        wrEdge             = accessEdge & busWriteEn;
        forceEmpty         = wrEdge && busAddress == ADDR_FORCE_EMPTY;
        dataWriteWhileFull = wrEdge && busAddress == ADDR_DATA && fifoFull;
        push               = wrEdge && busAddress == ADDR_DATA && !fifoFull;
        pop                = fifoREn & ~fifoEmpty & ~forceEmpty;
    end

    always_comb begin
        fifoEmpty         = count == '0;
        fifoFull          = count == FULL_COUNT;
        numElementsInFifo = 16'(count);
        busDataOut        = busAddress == ADDR_CNT_MSB ? numElementsInFifo[15:8] :
                            busAddress == ADDR_CNT_LSB ? numElementsInFifo[7:0]  :
                            busAddress == ADDR_STATUS  ? statusByte(overflow, fifoFull, fifoEmpty) :
                            8'h00;
    end

    always_ff @(posedge usbClk or negedge rstN) begin
        if (!rstN) begin
            accessPrev <= 1'b0;
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
        end else begin
            accessPrev <= busStrobe_i & busFifoSelect;
            if (forceEmpty) begin
                wrPtr <= '0;
                rdPtr <= '0;
                count <= '0;
            end else begin
                if (push) wrPtr <= wrPtr + PTR_ONE;
                if (pop)  rdPtr <= rdPtr + PTR_ONE;
                count <= count + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
            end
        end
    end

`ifdef TX_FIFO_OVERFLOW_FLAG_EN
    always_ff @(posedge usbClk or negedge rstN) begin
        if (!rstN)                   overflow <= 1'b0;
        else if (forceEmpty)         overflow <= 1'b0;
        else if (dataWriteWhileFull) overflow <= 1'b1;
    end
`else
    assign overflow = 1'b0;
`endif

    usb_tx_fifo_mem #(
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) mem (
        .usbClk (usbClk),
        .rstN   (rstN),
        .wrEn   (push),
        .wrAddr (wrPtr),
        .wrData (busDataIn),
        .rdEn   (pop),
        .rdAddr (rdPtr),
        .rdData (fifoDataOut)
    );

endmodule

// File: tb/tb_usb_tx_fifo.sv
// tb_usb_tx_fifo: directed table-driven and sequence checks for usb_tx_fifo.
module tb_usb_tx_fifo;

`ifdef TX_FIFO_OVERFLOW_FLAG_EN
    localparam logic [7:0] OVF = 8'h04;
`else
    localparam logic [7:0] OVF = 8'h00;
`endif

    logic        usbClk = 1'b0;
    logic        rstN = 1'b0;
    logic [2:0]  busAddress = 3'd0;
    logic        busWriteEn = 1'b0;
    logic        busStrobe_i = 1'b0;
    logic        busFifoSelect = 1'b0;
    logic [7:0]  busDataIn = 8'h00;
    logic [7:0]  busDataOut;
    logic        fifoREn = 1'b0;
    logic [7:0]  fifoDataOut;
    logic        fifoEmpty;
    logic        fifoFull;
    logic [15:0] numElementsInFifo;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         op;
        logic [7:0] data;
        int         cyc;
        int         expCount;
        logic       expEmpty;
        logic [7:0] expDout;
    } vec_t;

    vec_t vecs[7];

    usb_tx_fifo dut (
        .usbClk            (usbClk),
        .rstN              (rstN),
        .busAddress        (busAddress),
        .busWriteEn        (busWriteEn),
        .busStrobe_i       (busStrobe_i),
        .busFifoSelect     (busFifoSelect),
        .busDataIn         (busDataIn),
        .busDataOut        (busDataOut),
        .fifoREn           (fifoREn),
        .fifoDataOut       (fifoDataOut),
        .fifoEmpty         (fifoEmpty),
        .fifoFull          (fifoFull),
        .numElementsInFifo (numElementsInFifo)
    );

    always #5 usbClk = ~usbClk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the strobe released.
    task automatic busWrite(input logic [2:0] a, input logic [7:0] d, input int cyc, input logic withPop);
        busAddress = a;
        busDataIn = d;
        busWriteEn = 1'b1;
        busFifoSelect = 1'b1;
        busStrobe_i = 1'b1;
        fifoREn = withPop;
        @(negedge usbClk);
        fifoREn = 1'b0;
        repeat (cyc - 1) @(negedge usbClk);
        busStrobe_i = 1'b0;
        busWriteEn = 1'b0;
        @(negedge usbClk);
    endtask

    task automatic push(input logic [7:0] d);
        busWrite(3'd0, d, 1, 1'b0);
    endtask

    task automatic popOne();
        fifoREn = 1'b1;
        @(negedge usbClk);
        fifoREn = 1'b0;
    endtask

    task automatic readReg(input logic [2:0] a, output logic [7:0] d);
        busAddress = a;
        busWriteEn = 1'b0;
        #1 d = busDataOut;
    endtask

    initial begin
        logic [7:0] r;
        vecs = '{
            '{0, 8'hA5, 3, 1, 1'b0, 8'h00},
            '{0, 8'h3C, 3, 2, 1'b0, 8'h00},
            '{1, 8'h00, 1, 1, 1'b0, 8'hA5},
            '{1, 8'h00, 1, 0, 1'b1, 8'h3C},
            '{1, 8'h00, 1, 0, 1'b1, 8'h3C},
            '{0, 8'h11, 2, 1, 1'b0, 8'h3C},
            '{2, 8'hFF, 2, 0, 1'b1, 8'h3C}
        };

        repeat (2) @(negedge usbClk);
        readReg(3'd5, r); check("reset_status", r, 8'h01);
        readReg(3'd2, r); check("reset_cnt_msb", r, 8'h00);
        readReg(3'd3, r); check("reset_cnt_lsb", r, 8'h00);
        check("reset_dout", fifoDataOut, 8'h00);
        check("reset_full", fifoFull, 1'b0);
        rstN = 1'b1;
        @(negedge usbClk);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].op == 0) busWrite(3'd0, vecs[i].data, vecs[i].cyc, 1'b0);
            else if (vecs[i].op == 1) popOne();
            else busWrite(3'd4, vecs[i].data, vecs[i].cyc, 1'b0);
            check($sformatf("vec%0d_count", i), numElementsInFifo, 16'(vecs[i].expCount));
            check($sformatf("vec%0d_empty", i), fifoEmpty, vecs[i].expEmpty);
            if (vecs[i].op != 0) check($sformatf("vec%0d_dout", i), fifoDataOut, vecs[i].expDout);
        end

        // Offset pointers so the fill wraps mid-array.
        for (int i = 0; i < 5; i++) begin
            push(8'h90);
            popOne();
        end
        for (int i = 0; i < 64; i++) push(8'(i));
        check("fill_full", fifoFull, 1'b1);
        readReg(3'd3, r); check("fill_cnt_lsb", r, 8'h40);
        readReg(3'd2, r); check("fill_cnt_msb", r, 8'h00);
        readReg(3'd5, r); check("fill_status", r, 8'h02);
        push(8'hFF);
        check("overfill_count", numElementsInFifo, 16'd64);
        readReg(3'd5, r); check("overfill_status", r, 8'h02 | OVF);
        for (int i = 0; i < 64; i++) begin
            popOne();
            check($sformatf("drain%0d", i), fifoDataOut, 8'(i));
        end
        check("drain_empty", fifoEmpty, 1'b1);
        readReg(3'd5, r); check("drain_status", r, 8'h01 | OVF);
        busWrite(3'd4, 8'h00, 1, 1'b0);
        readReg(3'd5, r); check("force_clears_ovf", r, 8'h01);

        for (int i = 0; i < 10; i++) push(8'(10 + i));
        busWrite(3'd0, 8'h77, 1, 1'b1);
        check("pushpop_count", numElementsInFifo, 16'd10);
        check("pushpop_dout", fifoDataOut, 8'd10);
        for (int i = 0; i < 10; i++) begin
            popOne();
            check($sformatf("pp_drain%0d", i), fifoDataOut, i == 9 ? 8'h77 : 8'(11 + i));
        end
        check("pp_drain_count", numElementsInFifo, 16'd0);

        for (int i = 0; i < 64; i++) push(8'(100 + i));
        busWrite(3'd0, 8'hEE, 1, 1'b1);
        check("full_pushpop_count", numElementsInFifo, 16'd63);
        check("full_pushpop_dout", fifoDataOut, 8'd100);
        readReg(3'd5, r); check("full_pushpop_status", r, OVF);
        busWrite(3'd4, 8'h00, 1, 1'b0);
        check("force2_count", numElementsInFifo, 16'd0);

        for (int i = 0; i < 20; i++) push(8'(200 + i));
        readReg(3'd3, r); check("cnt20_lsb", r, 8'h14);
        busWrite(3'd4, 8'h55, 1, 1'b1);
        check("force_pop_count", numElementsInFifo, 16'd0);
        check("force_pop_empty", fifoEmpty, 1'b1);
        check("force_pop_dout", fifoDataOut, 8'd100);
        push(8'h5A);
        check("after_force_count", numElementsInFifo, 16'd1);
        popOne();
        check("after_force_dout", fifoDataOut, 8'h5A);

        for (int i = 0; i < 64; i++) push(8'(i));
        push(8'hFF);
        readReg(3'd5, r); check("ovf_status", r, 8'h02 | OVF);
        popOne();
        check("ovf_pop_dout", fifoDataOut, 8'h00);
        readReg(3'd5, r); check("ovf_after_pop", r, OVF);
        busWrite(3'd4, 8'h00, 1, 1'b0);
        readReg(3'd5, r); check("ovf_cleared", r, 8'h01);

        push(8'h21);
        push(8'h22);
        popOne();
        push(8'h23);
        #2 rstN = 1'b0;
        #1;
        check("async_rst_count", numElementsInFifo, 16'd0);
        check("async_rst_dout", fifoDataOut, 8'h00);
        readReg(3'd5, r); check("async_rst_status", r, 8'h01);
        @(negedge usbClk);
        rstN = 1'b1;
        @(negedge usbClk);
        push(8'h42);
        popOne();
        check("post_rst_dout", fifoDataOut, 8'h42);
        check("post_rst_empty", fifoEmpty, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
